// File: rtl/computer_move_engine.sv
// Tic-tac-toe opponent: snapshots the board, then searches win > block > preferred cell one candidate per cycle.
// Define COMPUTER_MOVE_BLOCK_EN to include the block-search phase.
module computer_move_engine (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       busy,
  output logic       no_move
);

  localparam logic [1:0] EMPTY = 2'b00, PLAYER = 2'b01, COMP = 2'b10;

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, SCAN_PREF, ISSUE, WAIT_REL} state_t;

  state_t           state, state_d;
  logic [8:0][1:0]  snap_board, snap_d, board_in;
  logic [3:0]       idx, idx_d, sel_d;
  logic             pc_d, busy_d, no_move_d;

  assign board_in = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  // Cell triple {c0,c1,c2} of line l
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] i);
    case (i)
      4'd0:    pref_cell = 4'd4;
      4'd1:    pref_cell = 4'd0;
      4'd2:    pref_cell = 4'd2;
      4'd3:    pref_cell = 4'd6;
      4'd4:    pref_cell = 4'd8;
      4'd5:    pref_cell = 4'd1;
      4'd6:    pref_cell = 4'd3;
      4'd7:    pref_cell = 4'd5;
      default: pref_cell = 4'd7;
    endcase
  endfunction

  logic [11:0] cells;
  logic [3:0]  c0, c1, c2, empty_cell, pcell;
  logic [1:0]  a, b, c, n_comp, n_empty;
  logic        win_hit, pref_hit;

  always_comb begin
    cells      = line_cells(idx[2:0]);
    c0         = cells[11:8];
    c1         = cells[7:4];
    c2         = cells[3:0];
    a          = snap_board[c0];
    b          = snap_board[c1];
    c          = snap_board[c2];
    n_comp     = 2'(a == COMP) + 2'(b == COMP) + 2'(c == COMP);
    n_empty    = 2'(a == EMPTY) + 2'(b == EMPTY) + 2'(c == EMPTY);
    empty_cell = (a == EMPTY) ? c0 : (b == EMPTY) ? c1 : c2;
    win_hit    = (n_comp == 2'd2) && (n_empty == 2'd1);
    pcell      = pref_cell(idx);
    pref_hit   = (snap_board[pcell] == EMPTY);
  end

`ifdef COMPUTER_MOVE_BLOCK_EN
  logic [1:0] n_ply;
  logic       blk_hit;
  always_comb begin
    n_ply   = 2'(a == PLAYER) + 2'(b == PLAYER) + 2'(c == PLAYER);
    blk_hit = (n_ply == 2'd2) && (n_empty == 2'd1);
  end
`endif

  always_comb begin
    state_d   = state;
    snap_d    = snap_board;
    idx_d     = idx;
    sel_d     = computer_position;
    pc_d      = 1'b0;
    busy_d    = busy;
    no_move_d = 1'b0;
    case (state)
      IDLE: if (req) begin
        snap_d  = board_in;
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = SCAN_WIN;
      end
      SCAN_WIN: begin
        if (!req) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (win_hit) begin
          sel_d   = empty_cell;
          pc_d    = 1'b1;
          state_d = ISSUE;
        end else if (idx == 4'd7) begin
          idx_d   = '0;
`ifdef COMPUTER_MOVE_BLOCK_EN
          state_d = SCAN_BLOCK;
`else
          state_d = SCAN_PREF;
`endif
        end else
          idx_d = idx + 4'd1;
      end
`ifdef COMPUTER_MOVE_BLOCK_EN
      SCAN_BLOCK: begin
        if (!req) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (blk_hit) begin
          sel_d   = empty_cell;
          pc_d    = 1'b1;
          state_d = ISSUE;
        end else if (idx == 4'd7) begin
          idx_d   = '0;
          state_d = SCAN_PREF;
        end else
          idx_d = idx + 4'd1;
      end
`endif
      SCAN_PREF: begin
        if (!req) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (pref_hit) begin
          sel_d   = pcell;
          pc_d    = 1'b1;
          state_d = ISSUE;
        end else if (idx == 4'd8) begin
          no_move_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = WAIT_REL;
        end else
          idx_d = idx + 4'd1;
      end
      ISSUE: begin
        busy_d  = 1'b0;
        state_d = WAIT_REL;
      end
      WAIT_REL: if (!req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      snap_board        <= '0;
      idx               <= '0;
      computer_position <= '0;
      pc                <= 1'b0;
      busy              <= 1'b0;
      no_move           <= 1'b0;
    end else begin
      state             <= state_d;
      snap_board        <= snap_d;
      idx               <= idx_d;
      computer_position <= sel_d;
      pc                <= pc_d;
      busy              <= busy_d;
      no_move           <= no_move_d;
    end
  end

endmodule

// File: tb/tb_computer_move_engine.sv
// Bench for computer_move_engine: vector table with a scoreboard of expected moves, plus abort/reset sequences.
module tb_computer_move_engine;

  localparam logic [1:0] EM = 2'b00, PL = 2'b01, CO = 2'b10, IV = 2'b11;
`ifdef COMPUTER_MOVE_BLOCK_EN
  localparam int         PF = 16;
  localparam logic [3:0] BLK_POS = 4'd5;
  localparam int         BLK_STEP = 10;
`else
  localparam int         PF = 8;
  localparam logic [3:0] BLK_POS = 4'd2;
  localparam int         BLK_STEP = 11;
`endif

  logic            clock = 1'b0, reset = 1'b1, req = 1'b0;
  logic [8:0][1:0] board_drv = '0;
  logic [3:0]      computer_position;
  logic            pc, busy, no_move;

  computer_move_engine dut (
    .clock(clock), .reset(reset), .req(req),
    .pos1(board_drv[0]), .pos2(board_drv[1]), .pos3(board_drv[2]),
    .pos4(board_drv[3]), .pos5(board_drv[4]), .pos6(board_drv[5]),
    .pos7(board_drv[6]), .pos8(board_drv[7]), .pos9(board_drv[8]),
    .computer_position(computer_position), .pc(pc), .busy(busy), .no_move(no_move)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0][1:0] board;
    bit              chg;
    bit              nm;
    logic [3:0]      pos;
    int              step;
  } vec_t;

  typedef struct {
    bit         nm;
    logic [3:0] pos;
    int         step;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[9];
  int         checks = 0, errors = 0, step_ctr = 0, pc_count = 0;
  logic [3:0] model_pos = 4'd0;

  function automatic logic [8:0][1:0] bd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    bd = {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (pc || no_move) begin
      if (pc) pc_count++;
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        check("kind_no_move", int'(no_move), int'(e.nm));
        check("kind_pc", int'(pc), int'(!e.nm));
        check("step", step_ctr, e.step);
        check("position", int'(computer_position), int'(e.pos));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    step_ctr++;
    observe();
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n, pc0;
    e.nm   = v.nm;
    e.step = v.step;
    if (v.nm) e.pos = model_pos;
    else begin
      e.pos     = v.pos;
      model_pos = v.pos;
    end
    @(negedge clock);
    board_drv = v.board;
    req       = 1'b1;
    step_ctr  = -1;
    pc0       = pc_count;
    sb.push_back(e);
    tick();
    check("busy_after_snapshot", int'(busy), 1);
    if (v.chg) begin
      @(negedge clock);
      board_drv = bd(IV, IV, IV, IV, IV, IV, IV, IV, IV);
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_waiting_for_move", 0, 1);
      sb.delete();
    end
    repeat (4) tick();
    check("pc_pulses", pc_count - pc0, v.nm ? 0 : 1);
    check("busy_done", int'(busy), 0);
    check("position_hold", int'(computer_position), int'(model_pos));
    @(negedge clock);
    req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int pc0;
    tbl[0] = '{bd(EM, EM, EM, EM, EM, EM, EM, EM, EM), 1'b0, 1'b0, 4'd4, PF + 1};
    tbl[1] = '{bd(CO, CO, EM, PL, PL, EM, EM, EM, EM), 1'b0, 1'b0, 4'd2, 1};
    tbl[2] = '{bd(CO, EM, EM, PL, PL, EM, EM, EM, EM), 1'b0, 1'b0, BLK_POS, BLK_STEP};
    tbl[3] = '{bd(CO, PL, CO, CO, PL, PL, PL, CO, CO), 1'b0, 1'b1, 4'd0, PF + 9};
    tbl[4] = '{bd(CO, IV, EM, EM, IV, EM, EM, EM, EM), 1'b0, 1'b0, 4'd2, PF + 3};
    tbl[5] = '{bd(EM, EM, EM, CO, CO, EM, CO, CO, EM), 1'b0, 1'b0, 4'd5, 2};
    tbl[6] = '{bd(EM, EM, CO, EM, EM, EM, CO, EM, EM), 1'b0, 1'b0, 4'd4, 8};
    tbl[7] = '{bd(IV, IV, IV, IV, IV, IV, IV, EM, IV), 1'b0, 1'b0, 4'd7, PF + 9};
    tbl[8] = '{bd(EM, EM, EM, EM, EM, EM, EM, EM, EM), 1'b1, 1'b0, 4'd4, PF + 1};

    #3;
    check("reset_pc", int'(pc), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_no_move", int'(no_move), 0);
    check("reset_position", int'(computer_position), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Abort: req drops so that the edge evaluating step 3 sees req=0
    @(negedge clock);
    board_drv = '0;
    req       = 1'b1;
    step_ctr  = -1;
    pc0       = pc_count;
    repeat (3) tick();
    check("abort_busy_before", int'(busy), 1);
    @(negedge clock);
    req = 1'b0;
    tick();
    check("abort_busy_after", int'(busy), 0);
    repeat (5) tick();
    check("abort_pc_pulses", pc_count - pc0, 0);

    // Asynchronous reset in the middle of step 5
    @(negedge clock);
    req      = 1'b1;
    step_ctr = -1;
    repeat (5) tick();
    check("mid_busy_before_reset", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_pc", int'(pc), 0);
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_no_move", int'(no_move), 0);
    check("mid_reset_position", int'(computer_position), 0);
    req       = 1'b0;
    model_pos = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) tick();
    run_vec(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
